// File: rtl/exec_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing,
// ALU/mux control decode, sticky illegal-instruction trap and retire counter.
module exec_ctrl (
  input  logic        clk,
  input  logic        rst,
  output logic        instr_req,
  input  logic        instr_ack,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func_3,
  input  logic        func_7_b5,
  input  logic        branchsignal,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic [3:0]  op,
  output logic [2:0]  imme_sel,
  output logic [1:0]  rs_sel,
  output logic        bena,
  output logic        ir_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [31:0] instret
);
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM   = 3'd3, S_WB     = 3'd4, S_TRAP = 3'd5
  } state_e;

  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03, OP_ST = 7'h23,
                         OP_BR = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67,
                         OP_LUI = 7'h37, OP_AUIPC = 7'h17;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        is_ld, is_st, is_br, legal;

  assign is_ld = (opcode == OP_LD);
  assign is_st = (opcode == OP_ST);
  assign is_br = (opcode == OP_BR);
  assign legal = (opcode == OP_R) || (opcode == OP_I) || is_ld || is_st || is_br ||
                 (opcode == OP_JAL) || (opcode == OP_JALR) ||
                 (opcode == OP_LUI) || (opcode == OP_AUIPC);

  // func_7_b5 selects SUB only for register-register ops; shifts honour it always
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'd0:    return (alt && is_r) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (instr_ack) state_d = S_DECODE;
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC:   state_d = (is_ld || is_st) ? S_MEM : (is_br ? S_FETCH : S_WB);
      S_MEM:    if (mem_ack) state_d = is_ld ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Everything is forced low while rst is high so the reset cycle reads all-zero
  always_comb begin
    instr_req = 1'b0; ir_we = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    op = ALU_ADD; imme_sel = 3'd0; rs_sel = 2'd0; bena = 1'b0;
    reg_we = 1'b0; pc_we = 1'b0; pc_sel = 1'b0; wb_sel = 2'd0; trap = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          instr_req = 1'b1;
          ir_we     = instr_ack;
        end
        S_EXEC: begin
          case (opcode)
            OP_R:          op = alu_op(func_3, func_7_b5, 1'b1);
            OP_I: begin    op = alu_op(func_3, func_7_b5, 1'b0); imme_sel = 3'd1; end
            OP_LD, OP_JALR: imme_sel = 3'd1;
            OP_ST:         imme_sel = 3'd2;
            OP_BR: begin
              rs_sel = 2'd1; imme_sel = 3'd3; bena = 1'b1;
              pc_we  = 1'b1; pc_sel = branchsignal;
            end
            OP_JAL: begin  rs_sel = 2'd1; imme_sel = 3'd4; end
            OP_LUI: begin  rs_sel = 2'd2; imme_sel = 3'd5; op = ALU_PASSB; end
            OP_AUIPC: begin rs_sel = 2'd1; imme_sel = 3'd5; end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = is_st;
          pc_we   = is_st && mem_ack;
        end
        S_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          if (opcode == OP_JAL || opcode == OP_JALR) begin
            wb_sel = 2'd2; pc_sel = 1'b1;
          end else if (is_ld) begin
            wb_sel = 2'd1;
          end
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign instret_d = instret_q + {31'd0, pc_we};
  assign instret   = rst ? 32'd0 : instret_q;
endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have ports clk (in, 1, sole clock) and rst (in, 1); reset is synchronous and active-high.
REQ-002 SHALL have ports instr_req (out, 1, fetch request) and instr_ack (in, 1, fetch data valid).
REQ-003 SHALL have ports opcode (in, 7), func_3 (in, 3) and func_7_b5 (in, 1), all decoded from the instruction register.
REQ-004 SHALL have port branchsignal (in, 1, branch-taken result from the execute stage).
REQ-005 SHALL have ports mem_req (out, 1), mem_we (out, 1) and mem_ack (in, 1) for data memory.
REQ-006 SHALL have port op (out, 4, ALU op): ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
REQ-007 SHALL have port imme_sel (out, 3): rs2=0, i=1, s=2, b=3, uj=4, u=5.
REQ-008 SHALL have port rs_sel (out, 2): rs1=0, pc_out=1, zero=2.
REQ-009 SHALL have port bena (out, 1, enables the branch comparator).
REQ-010 SHALL have ports ir_we, reg_we and pc_we (out, 1 each), which are write enables.
REQ-011 SHALL have port pc_sel (out, 1): pc+4=0, ALU out=1.
REQ-012 SHALL have port wb_sel (out, 2): ALU=0, load data=1, pc+4=2.
REQ-013 SHALL have ports trap (out, 1, sticky illegal-instruction flag) and instret (out, 32, retired-instruction count).

Function
REQ-014 SHALL implement the Moore FSM FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; all outputs SHALL be registered-state decoded with no combinational path from the ack inputs to the req outputs.
REQ-015 FETCH SHALL hold instr_req=1 until instr_ack; in the ack cycle it SHALL assert ir_we=1 and go to DECODE.
REQ-016 DECODE SHALL last one cycle: opcodes R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI and AUIPC go to EXEC; any other opcode goes to TRAP.
REQ-017 EXEC ALU controls:
- R-type: rs_sel=0, imme_sel=0, op from func_3/func_7_b5 (SUB and SRA when func_7_b5=1).
- I-ALU: imme_sel=1, same op mapping, with func_7_b5 honoured only for shifts.
- LOAD/JALR: op=ADD, imme_sel=1.
- STORE: op=ADD, imme_sel=2.
- BRANCH: rs_sel=1, imme_sel=3, op=ADD, bena=1.
- JAL: rs_sel=1, imme_sel=4, op=ADD.
- LUI: rs_sel=2, imme_sel=5, op=PASSB.
- AUIPC: rs_sel=1, imme_sel=5, op=ADD.
REQ-018 EXEC transitions:
- LOAD/STORE go to MEM.
- BRANCH asserts pc_we=1 and pc_sel=branchsignal, then goes to FETCH.
- All other opcodes go to WB.
REQ-019 MEM SHALL hold mem_req=1 and mem_we=(STORE) until mem_ack. On ack, LOAD goes to WB; STORE asserts pc_we=1, pc_sel=0 and goes to FETCH.
REQ-020 WB SHALL assert reg_we=1 for one cycle and pc_we=1. For JAL/JALR it SHALL drive wb_sel=2 and pc_sel=1; for LOAD, wb_sel=1 and pc_sel=0; otherwise wb_sel=0 and pc_sel=0. It then goes to FETCH.
REQ-021 instret SHALL increment by 1 (mod 2^32, wrapping 0xFFFFFFFF to 0) on every pc_we cycle.
REQ-022 TRAP SHALL set trap=1 and hold all enables and requests at 0; only rst SHALL exit TRAP.
REQ-023 Any output not listed for a state SHALL be 0, so at most one of ir_we, reg_we and pc_we is 1 except in the WB and EXEC-branch rules above.
REQ-024 Acks SHALL be ignored in any state that is not requesting; an ack in the same cycle as the request's first assertion SHALL be accepted.

Reset
REQ-025 While rst=1 at a rising edge, the FSM SHALL go to FETCH, instret and trap SHALL clear to 0, and all outputs SHALL read 0 in that cycle.
REQ-026 Reset mid-request (in MEM or FETCH) SHALL abort with no pc_we or reg_we, and SHALL re-issue instr_req on the first cycle after rst deasserts.

Verification
REQ-027 Fetch an ADD (opcode 0x33, func_3=0, func_7_b5=0) with instr_ack on cycle 2 -> ir_we is seen once, the FSM passes DECODE and EXEC (op=0), WB shows reg_we=1 and pc_we=1, and instret=1.
REQ-028 Fetch a LW with mem_ack delayed 3 cycles -> mem_req=1 and mem_we=0 are held for 4 cycles, then WB shows wb_sel=1.
REQ-029 Fetch a BEQ with branchsignal=1 -> EXEC shows bena=1, pc_we=1 and pc_sel=1, with no reg_we, then returns to FETCH.
REQ-030 Apply opcode 0x7F -> trap=1 in the cycle after DECODE, with no further instr_req; rst=1 clears trap.
REQ-031 Assert rst during MEM of a SW -> no pc_we, instret is unchanged at 0, and instr_req=1 on the first cycle after release.
REQ-032 Preload instret to 0xFFFFFFFF via a forced state, then retire one instruction -> instret=0.
